vic_config_regfile: RTL and testbench

Parametrised configuration/status register file for the VIC (vectored interrupt controller). It holds one priority register per interrupt channel, a control register with global enable and a sticky lock bit, and a per-channel pending bit. Pending bits are set on IRQ rising edges and cleared by write-1-to-clear. It sits between the CPU-side register bus and the VIC arbitration logic. Compared with the previous fixed 32x4 block, it adds registered reads with a valid strobe, write-error reporting, write lock and pending capture.

---
 rtl/vic_config_regfile.sv | 111 +++++++++++
 tb/tb_vic_config_regfile.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vic_config_regfile.sv
// VIC configuration/status register file: per-channel priorities, control (enable/lock),
// and per-channel pending bits captured on IRQ rising edges with write-1-to-clear.
module vic_config_regfile #(
    parameter int NUM_CH     = 31,
    parameter int PRIO_WIDTH = 4,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        i_VIC_regaddr,
    input  logic [PRIO_WIDTH-1:0]        i_VIC_data,
    input  logic                         i_VIC_we,
    input  logic                         i_VIC_re,
    output logic [PRIO_WIDTH-1:0]        o_VIC_data,
    output logic                         o_VIC_rvalid,
    output logic                         o_VIC_werr,
    input  logic [NUM_CH-1:0]            i_irq,
    output logic                         o_enable,
    output logic                         o_lock,
    output logic [NUM_CH*PRIO_WIDTH-1:0] o_prio,
    output logic [NUM_CH-1:0]            o_pending
);

    // One extra address bit so map boundaries compare without overflow.
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] CTRL_ADDR = AW1'(NUM_CH);
    localparam logic [AW1-1:0] PEND_BASE = AW1'(NUM_CH + 1);
    localparam logic [AW1-1:0] MAP_END   = AW1'(2 * NUM_CH + 1);

    logic [AW1-1:0]               addr;
    logic [NUM_CH*PRIO_WIDTH-1:0] prio_q;
    logic                         enable_q;
    logic                         lock_q;
    logic [NUM_CH-1:0]            pending_q;
    logic [NUM_CH-1:0]            irq_q;
    logic [NUM_CH-1:0]            prio_sel;
    logic [NUM_CH-1:0]            pend_sel;
    logic [NUM_CH-1:0]            prio_nz;
    logic [NUM_CH-1:0]            pend_set;
    logic [NUM_CH-1:0]            pend_clr;
    logic                         ctrl_sel;
    logic                         mapped;
    logic                         wr_reject;
    logic                         rd_fire;
    logic [PRIO_WIDTH-1:0]        rd_data;

    assign addr = {1'b0, i_VIC_regaddr};

    always_comb begin
        prio_sel = '0;
        pend_sel = '0;
        prio_nz  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            prio_sel[i] = (addr == AW1'(i));
            pend_sel[i] = (addr == PEND_BASE + AW1'(i));
            prio_nz[i]  = |prio_q[PRIO_WIDTH*i +: PRIO_WIDTH];
        end
        ctrl_sel = (addr == CTRL_ADDR);
        mapped   = (addr < MAP_END);
    end

    // Zero-priority channels never latch a pending request.
    assign pend_set  = i_irq & ~irq_q & prio_nz;
    assign pend_clr  = (i_VIC_we && i_VIC_data[0]) ? pend_sel : '0;
    assign wr_reject = i_VIC_we && (!mapped || (lock_q && ((|prio_sel) || ctrl_sel)));
    assign rd_fire   = i_VIC_re && !i_VIC_we;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (prio_sel[i]) rd_data = prio_q[PRIO_WIDTH*i +: PRIO_WIDTH];
            if (pend_sel[i]) rd_data[0] = pending_q[i];
        end
        if (ctrl_sel) rd_data[1:0] = {lock_q, enable_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q       <= '0;
            enable_q     <= 1'b0;
            lock_q       <= 1'b0;
            pending_q    <= '0;
            irq_q        <= '0;
            o_VIC_data   <= '0;
            o_VIC_rvalid <= 1'b0;
            o_VIC_werr   <= 1'b0;
        end else begin
            irq_q <= i_irq;
            // Set is OR'd after the clear so a coincident edge keeps the bit.
            pending_q <= (pending_q & ~pend_clr) | pend_set;
            if (i_VIC_we && !lock_q) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (prio_sel[i]) prio_q[PRIO_WIDTH*i +: PRIO_WIDTH] <= i_VIC_data;
                end
                if (ctrl_sel) begin
                    enable_q <= i_VIC_data[0];
                    lock_q   <= i_VIC_data[1];
                end
            end
            o_VIC_werr   <= wr_reject;
            o_VIC_rvalid <= rd_fire;
            if (rd_fire) o_VIC_data <= rd_data;
        end
    end

    assign o_enable  = enable_q;
    assign o_lock    = lock_q;
    assign o_prio    = prio_q;
    assign o_pending = pending_q;

endmodule

// File: tb/tb_vic_config_regfile.sv
// Self-checking bench for vic_config_regfile: table-driven register accesses with a
// read-data scoreboard, plus hand-written pending-capture and lock sequences.
module tb_vic_config_regfile;

    localparam int NUM_CH = 31;
    localparam int PW     = 4;
    localparam int AW     = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     i_VIC_regaddr;
    logic [PW-1:0]     i_VIC_data;
    logic              i_VIC_we;
    logic              i_VIC_re;
    logic [PW-1:0]     o_VIC_data;
    logic              o_VIC_rvalid;
    logic              o_VIC_werr;
    logic [NUM_CH-1:0] i_irq;
    logic              o_enable;
    logic              o_lock;
    logic [NUM_CH*PW-1:0] o_prio;
    logic [NUM_CH-1:0] o_pending;

    int checks = 0;
    int passes = 0;
    logic [PW-1:0] exp_q[$];

    typedef struct {
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
        logic [PW-1:0] exp_rd;
        logic          exp_werr;
    } vec_t;

    vec_t vecs[16];

    vic_config_regfile #(.NUM_CH(NUM_CH), .PRIO_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_VIC_regaddr(i_VIC_regaddr), .i_VIC_data(i_VIC_data),
        .i_VIC_we(i_VIC_we), .i_VIC_re(i_VIC_re),
        .o_VIC_data(o_VIC_data), .o_VIC_rvalid(o_VIC_rvalid), .o_VIC_werr(o_VIC_werr),
        .i_irq(i_irq), .o_enable(o_enable), .o_lock(o_lock),
        .o_prio(o_prio), .o_pending(o_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Compare the cycle's strobes; pop the scoreboard whenever read data comes back.
    task automatic checkOutput(input string tag, input logic exp_rv, input logic exp_werr);
        logic [PW-1:0] e;
        check({tag, " rvalid"}, 64'(o_VIC_rvalid), 64'(exp_rv));
        if (o_VIC_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL %s unexpected_rdata: got %0h, expected none", tag, o_VIC_data);
            end else begin
                e = exp_q.pop_front();
                check({tag, " rdata"}, 64'(o_VIC_data), 64'(e));
            end
        end
        check({tag, " werr"}, 64'(o_VIC_werr), 64'(exp_werr));
    endtask

    task automatic applyStimulus(input string tag, input logic we, input logic re,
                                 input logic [AW-1:0] addr, input logic [PW-1:0] data,
                                 input logic [PW-1:0] exp_rd, input logic exp_werr);
        i_VIC_we      = we;
        i_VIC_re      = re;
        i_VIC_regaddr = addr;
        i_VIC_data    = data;
        if (re && !we) exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        i_VIC_we = 1'b0;
        i_VIC_re = 1'b0;
        checkOutput(tag, re && !we, exp_werr);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 6'd5,  4'hA, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 6'd5,  4'h0, 4'hA, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 6'd0,  4'h1, 4'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 6'd0,  4'h0, 4'h1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 6'd30, 4'hF, 4'h0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 6'd30, 4'h0, 4'hF, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 6'd6,  4'h0, 4'h0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 6'd31, 4'h0, 4'h0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 6'd40, 4'h0, 4'h0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 6'd63, 4'hF, 4'h0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 6'd63, 4'h0, 4'h0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 6'd5,  4'h9, 4'h0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 6'd5,  4'h0, 4'h9, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 6'd5,  4'hA, 4'h0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 6'd62, 4'h0, 4'h0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 6'd62, 4'h1, 4'h0, 1'b0};

        rst = 1'b1;
        i_irq = '0;
        i_VIC_we = 1'b0;
        i_VIC_re = 1'b0;
        i_VIC_regaddr = '0;
        i_VIC_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", 64'(o_VIC_data), 64'd0);
        check("reset rvalid", 64'(o_VIC_rvalid), 64'd0);
        check("reset werr", 64'(o_VIC_werr), 64'd0);
        check("reset prio", 64'(o_prio[63:0]), 64'd0);
        check("reset prio_hi", 64'(o_prio[NUM_CH*PW-1:64]), 64'd0);
        check("reset pending", 64'(o_pending), 64'd0);
        check("reset ctrl", 64'({o_lock, o_enable}), 64'd0);
        rst = 1'b0;

        for (int a = 0; a < 64; a++)
            applyStimulus($sformatf("rd_all%0d", a), 1'b0, 1'b1, AW'(a), '0, '0, 1'b0);

        for (int v = 0; v < $size(vecs); v++)
            applyStimulus($sformatf("vec%0d", v), vecs[v].we, vecs[v].re, vecs[v].addr,
                          vecs[v].data, vecs[v].exp_rd, vecs[v].exp_werr);
        idle("hold");
        check("rdata_hold", 64'(o_VIC_data), 64'h0);
        check("prio5", 64'(o_prio[23:20]), 64'hA);
        check("prio0", 64'(o_prio[3:0]), 64'h1);
        check("prio6", 64'(o_prio[27:24]), 64'h0);
        check("prio30", 64'(o_prio[123:120]), 64'hF);

        // Pending capture: zero priority blocks, held level sets once.
        i_irq[5] = 1'b1;
        i_irq[6] = 1'b1;
        idle("irq_rise");
        check("pend5_set", 64'(o_pending[5]), 64'd1);
        check("pend6_blocked", 64'(o_pending[6]), 64'd0);
        repeat (9) idle("irq_hold");
        applyStimulus("rd_pend5", 1'b0, 1'b1, 6'd37, '0, 4'h1, 1'b0);
        applyStimulus("rd_pend6", 1'b0, 1'b1, 6'd38, '0, 4'h0, 1'b0);
        applyStimulus("w1c_held", 1'b1, 1'b0, 6'd37, 4'h1, '0, 1'b0);
        check("pend5_cleared", 64'(o_pending[5]), 64'd0);
        idle("held1");
        idle("held2");
        check("pend5_no_reset_by_level", 64'(o_pending[5]), 64'd0);
        i_irq[5] = 1'b0;
        idle("irq_low");
        i_irq[5] = 1'b1;
        idle("irq_rise2");
        check("pend5_reset", 64'(o_pending[5]), 64'd1);
        i_irq[5] = 1'b0;
        idle("irq_low2");
        i_irq[5] = 1'b1;
        applyStimulus("w1c_vs_set", 1'b1, 1'b0, 6'd37, 4'h1, '0, 1'b0);
        check("set_wins", 64'(o_pending[5]), 64'd1);
        applyStimulus("w1c_noedge", 1'b1, 1'b0, 6'd37, 4'h1, '0, 1'b0);
        check("pend5_w1c", 64'(o_pending[5]), 64'd0);

        i_irq = '0;
        idle("irq_clear");
        i_irq[0]  = 1'b1;
        i_irq[30] = 1'b1;
        idle("irq_edges");
        check("pend_edges", 64'(o_pending), 64'h4000_0001);
        applyStimulus("rd_pend0", 1'b0, 1'b1, 6'd32, '0, 4'h1, 1'b0);
        applyStimulus("rd_pend30", 1'b0, 1'b1, 6'd62, '0, 4'h1, 1'b0);
        i_irq = '0;

        // Lock: priority/control writes rejected, W1C still allowed.
        applyStimulus("wr_lock", 1'b1, 1'b0, 6'd31, 4'h3, '0, 1'b0);
        check("locked_ctrl", 64'({o_lock, o_enable}), 64'h3);
        applyStimulus("wr_prio_locked", 1'b1, 1'b0, 6'd5, 4'h7, '0, 1'b1);
        applyStimulus("wr_ctrl_locked", 1'b1, 1'b0, 6'd31, 4'h0, '0, 1'b1);
        applyStimulus("w1c_locked", 1'b1, 1'b0, 6'd32, 4'h1, '0, 1'b0);
        check("pend_after_w1c", 64'(o_pending), 64'h4000_0000);
        applyStimulus("rd_prio5_locked", 1'b0, 1'b1, 6'd5, '0, 4'hA, 1'b0);
        applyStimulus("rd_ctrl_locked", 1'b0, 1'b1, 6'd31, '0, 4'h3, 1'b0);
        check("lock_sticky", 64'({o_lock, o_enable}), 64'h3);
        check("prio5_kept", 64'(o_prio[23:20]), 64'hA);

        rst = 1'b1;
        applyStimulus("reset_wr", 1'b1, 1'b0, 6'd5, 4'h7, '0, 1'b0);
        rst = 1'b0;
        check("rst_ctrl", 64'({o_lock, o_enable}), 64'd0);
        check("rst_prio", 64'(o_prio[63:0]), 64'd0);
        check("rst_pending", 64'(o_pending), 64'd0);
        check("rst_rdata", 64'(o_VIC_data), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
